// File: rtl/mem_access_ctrl.sv
// Memory-stage bus access controller: IDLE -> REQ -> DONE handshake between pipeline and memory bus.
// Latency 1 + N stall cycles (N = REQ cycles incl. ack, capped at TIMEOUT); faults take 1 stall cycle; stall freezes the pipeline.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] cnt;
    logic       access;
    logic       fault;

    assign access = mem_re | mem_we;
    assign fault  = (mem_re & mem_we) | (access & (mem_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack arriving on the final timeout cycle still completes the access.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (fault) begin
                    state_nxt = DONE;
                end else if (access) begin
                    state_nxt = REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ:     state_nxt = (bus_ack || cnt == TO_LAST) ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = ((state == IDLE) & access) | (state == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fault) begin
                        mem_err <= 1'b1;
                    end else if (access) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        mem_err <= 1'b0;
                        if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                        if (cnt == TO_LAST) begin
                            bus_req <= 1'b0;
                            mem_err <= 1'b1;
                        end
                    end
                end
                // mem_err is only meaningful during DONE
                DONE:    mem_err <= 1'b0;
                default: bus_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: driver predicts each access, monitor checks the DONE response.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          stall_n;
        int          breq_n;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: a fault costs one stall cycle; otherwise the access lasts until
    // the ack cycle or TO request cycles, whichever comes first.
    task automatic txn(input logic re, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_at,
                       input logic [31:0] rd, input bit hold);
        exp_t e;
        bit   fault;
        bit   done;
        int   c;
        int   cyc;
        fault   = (re && we) || (addr[1:0] != 2'b00);
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        if (fault) begin
            e.err = 1'b1; e.stall_n = 1; e.breq_n = 0;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            e.err = 1'b0; e.stall_n = 1 + ack_at; e.breq_n = ack_at;
            if (!we) model_rdata = rd;
        end else begin
            e.err = 1'b1; e.stall_n = 1 + TO; e.breq_n = TO;
        end
        e.rdata = model_rdata;
        exp_q.push_back(e);

        @(negedge clk);
        mem_re = re; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        c = 0; cyc = 0; done = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            if (!stall) begin
                done = 1;
            end else if (bus_req) begin
                c++;
                if (c == ack_at) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end else begin
                    bus_rdata = $urandom;
                end
            end
        end
        check("txn_completes", {31'd0, done}, 32'd1);
        if (!hold) begin
            mem_re = 1'b0; mem_we = 1'b0;
        end
    endtask

    int   mon_scnt = 0;
    int   mon_bcnt = 0;
    bit   mon_prev = 0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_scnt = 0; mon_bcnt = 0; mon_prev = 0;
            end else begin
                if (bus_req) begin
                    mon_bcnt++;
                    if (exp_q.size() == 0) begin
                        check("bus_req_unexpected", {31'd0, bus_req}, 32'd0);
                    end else begin
                        check("bus_we", {31'd0, bus_we}, {31'd0, exp_q[0].we});
                        check("bus_addr", bus_addr, exp_q[0].addr);
                        check("bus_wdata", bus_wdata, exp_q[0].wdata);
                    end
                end
                if (stall) begin
                    mon_scnt++;
                end else if (mon_prev) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("mem_err", {31'd0, mem_err}, {31'd0, mon_e.err});
                        check("mem_rdata", mem_rdata, mon_e.rdata);
                        check("stall_cycles", 32'(mon_scnt), 32'(mon_e.stall_n));
                        check("bus_req_cycles", 32'(mon_bcnt), 32'(mon_e.breq_n));
                    end
                    mon_scnt = 0; mon_bcnt = 0;
                end
                mon_prev = stall;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          k;
        logic        re;
        logic        we;
        logic [31:0] a;

        rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #3;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_stall_idle", {31'd0, stall}, 32'd0);
        mem_re = 1'b1;
        #1;
        check("rst_stall_access", {31'd0, stall}, 32'd1);
        mem_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        txn(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 2, 32'h5555_AAAA, 0);
        txn(1'b1, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h0BAD_0001, 0);
        txn(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_0000, 1, 32'h0BAD_0002, 0);

        // timeout, then acks landing in DONE and IDLE must be ignored
        txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0, 0);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #2;
        check("late_ack_rdata", mem_rdata, model_rdata);
        check("late_ack_bus_req", {31'd0, bus_req}, 32'd0);

        txn(1'b1, 1'b0, 32'h0000_0408, 32'h0, TO, 32'hA5A5_0F0F, 0);

        // request held across DONE restarts from IDLE
        txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h1111_2222, 1);
        txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2, 32'h3333_4444, 0);

        // asynchronous reset in the middle of REQ
        e.err = 1'b0; e.rdata = '0; e.stall_n = 0; e.breq_n = 0;
        e.we = 1'b0; e.addr = 32'h0000_0500; e.wdata = 32'h7777_0000;
        exp_q.push_back(e);
        @(negedge clk);
        mem_re = 1'b1; mem_addr = 32'h0000_0500; mem_wdata = 32'h7777_0000;
        @(negedge clk);
        #3;
        check("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_bus_addr", bus_addr, 32'd0);
        check("mid_rst_bus_wdata", bus_wdata, 32'd0);
        check("mid_rst_mem_rdata", mem_rdata, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd1);
        mem_re = 1'b0;
        #1;
        check("mid_rst_stall_noacc", {31'd0, stall}, 32'd0);
        exp_q.delete();
        model_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn(1'b0, 1'b1, 32'h0000_0600, 32'h8888_9999, 1, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 3);
            re = (k != 1);
            we = (k == 1 || k == 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            txn(re, we, a, $urandom, $urandom_range(1, 6), $urandom, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum REQ-state cycles before an access aborts; valid range 1..1023.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port mem_re  input  1  memory-stage read request; held stable by the pipeline while stall=1.
REQ-005 Port mem_we  input  1  memory-stage write request; held stable while stall=1.
REQ-006 Port mem_addr  input  32  byte address (memory-stage ALU result).
REQ-007 Port mem_wdata  input  32  store data.
REQ-008 Port stall  output  1  freeze request to the upstream pipeline registers.
REQ-009 Port mem_rdata  output  32  load data; registered.
REQ-010 Port mem_err  output  1  access fault; registered; valid only in DONE.
REQ-011 Port bus_req  output  1  memory-bus request; registered.
REQ-012 Port bus_we  output  1  bus write qualifier; registered.
REQ-013 Port bus_addr  output  32  bus address; registered.
REQ-014 Port bus_wdata  output  32  bus write data; registered.
REQ-015 Port bus_ack  input  1  bus completion; one-cycle pulse.
REQ-016 Port bus_rdata  input  32  bus read data; valid when bus_ack=1.

Function
REQ-017 States SHALL be IDLE, REQ and DONE, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge.
REQ-018 access SHALL be defined as mem_re|mem_we; fault SHALL be defined as (mem_re&mem_we) | (access & mem_addr[1:0]!=0).
REQ-019 stall SHALL be combinational: (IDLE & access) | REQ; it SHALL be 0 in DONE.
REQ-020 IDLE & access & ~fault: next state REQ; capture bus_addr=mem_addr, bus_wdata=mem_wdata, bus_we=mem_we; set bus_req=1; clear the timeout counter.
REQ-021 IDLE & fault: next state DONE with mem_err=1; no bus request is issued.
REQ-022 In REQ, bus_req, bus_we, bus_addr and bus_wdata SHALL remain constant until bus_ack or timeout.
REQ-023 REQ & bus_ack: next state DONE; bus_req=0; mem_err=0; if bus_we=0, mem_rdata=bus_rdata, otherwise mem_rdata is unchanged.
REQ-024 REQ & ~bus_ack: the 10-bit counter SHALL increment; when the counter equals TIMEOUT-1, next state SHALL be DONE with mem_err=1 and bus_req=0; mem_rdata is unchanged.
REQ-025 bus_ack and timeout in the same cycle: bus_ack SHALL win (mem_err=0).
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; request inputs seen during DONE SHALL NOT start an access.
REQ-027 bus_ack outside REQ SHALL be ignored.
REQ-028 Latency, aligned access: stall high for 1 + N cycles, where N is the number of REQ cycles up to and including the ack cycle; the result is valid in DONE.
REQ-029 Latency, fault: stall high for 1 cycle, followed by 1 DONE cycle.
REQ-030 Back-to-back accesses SHALL be separated by exactly one DONE cycle and one IDLE cycle.

Reset
REQ-031 rst=1 SHALL force, immediately and independent of clk: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_rdata=0, mem_err=0, counter=0.
REQ-032 With rst=1, stall SHALL follow REQ-019 in IDLE, i.e. stall=access.
REQ-033 Reset asserted during REQ SHALL drop bus_req within the same cycle; no completion or DONE state follows.

Verification
REQ-034 Read: mem_re=1, addr=0x100, bus_ack after 3 cycles with rdata=0xDEADBEEF -> stall high 4 cycles; DONE shows mem_rdata=0xDEADBEEF, mem_err=0.
REQ-035 Write: mem_we=1, addr=0x204, wdata=0x12345678 -> bus_req=1, bus_we=1, bus_addr=0x204, bus_wdata=0x12345678 stable until ack; mem_rdata unchanged.
REQ-036 Misaligned: mem_re=1, addr=0x103 -> bus_req never asserted; 1 stall cycle, then DONE with mem_err=1; mem_re&mem_we=1 gives the same response.
REQ-037 Timeout: TIMEOUT=4, no ack -> bus_req high exactly 4 cycles; DONE with mem_err=1; a late bus_ack is ignored.
REQ-038 Simultaneous events: ack on the TIMEOUT-1 cycle -> mem_err=0 and data captured; a request held across DONE -> one DONE cycle, then a fresh access starts from IDLE.
REQ-039 Reset mid-REQ: rst asserted asynchronously between edges -> bus_req=0 and all outputs at reset values before the next edge; operation resumes from IDLE after release.
